// File: rtl/io_clk_edge_monitor_if.sv
// Bundle between the divided IO clock source/control side and the sys_clk edge monitor.
// The master drives the divided clock, select code and controls; the slave returns strobes and measurements.
interface io_clk_edge_monitor_if #(
    parameter int PERIOD_W = 16,
    parameter int STALL_W  = 16
);
    logic                clk_en;
    logic                divided_clk;
    logic [1:0]          divided_clk_sel;
    logic [STALL_W-1:0]  stall_limit;
    logic                rise_strobe;
    logic                fall_strobe;
    logic                divided_clk_sync;
    logic [1:0]          sel_sync;
    logic [PERIOD_W-1:0] period_out;
    logic                period_valid;
    logic                period_ovf;
    logic                stalled;

    modport master (
        output clk_en,
        output divided_clk,
        output divided_clk_sel,
        output stall_limit,
        input  rise_strobe,
        input  fall_strobe,
        input  divided_clk_sync,
        input  sel_sync,
        input  period_out,
        input  period_valid,
        input  period_ovf,
        input  stalled
    );

    modport slave (
        input  clk_en,
        input  divided_clk,
        input  divided_clk_sel,
        input  stall_limit,
        output rise_strobe,
        output fall_strobe,
        output divided_clk_sync,
        output sel_sync,
        output period_out,
        output period_valid,
        output period_ovf,
        output stalled
    );
endinterface

// File: rtl/io_clk_edge_monitor.sv
// Synchronises the divided IO clock into sys_clk, produces rise/fall strobes,
// measures the divided period in sys_clk cycles and flags a stalled divided clock.
module io_clk_edge_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 16,
    parameter int STALL_W     = 16
) (
    input  logic                 sys_clk,
    input  logic                 async_rst,
    io_clk_edge_monitor_if.slave mon
);

    localparam logic [1:0] ST_WAIT_FIRST  = 2'd0;
    localparam logic [1:0] ST_WAIT_SECOND = 2'd1;
    localparam logic [1:0] ST_LOCKED      = 2'd2;

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0]  STALL_MAX  = {STALL_W{1'b1}};
    localparam logic [STALL_W-1:0]  STALL_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0]      clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0][1:0] sel_sync_q, sel_sync_d;
    logic                        clk_hist_q, clk_hist_d;
    logic [1:0]                  sel_hist_q, sel_hist_d;
    logic                        rise_evt_q, rise_evt_d;
    logic                        fall_evt_q, fall_evt_d;
    logic                        rise_strobe_q, rise_strobe_d;
    logic                        fall_strobe_q, fall_strobe_d;
    logic [1:0]                  state_q, state_d;
    logic [PERIOD_W-1:0]         period_cnt_q, period_cnt_d;
    logic                        cnt_ovf_q, cnt_ovf_d;
    logic [PERIOD_W-1:0]         period_out_q, period_out_d;
    logic                        period_ovf_q, period_ovf_d;
    logic                        period_valid_q, period_valid_d;
    logic [STALL_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic                        stalled_q, stalled_d;

    logic                        clk_sync_lvl;
    logic [1:0]                  sel_sync_lvl;
    logic                        edge_evt;
    logic                        sel_change;
    logic                        stall_trip;
    logic                        cnt_at_max;
    logic [PERIOD_W-1:0]         cap_period;
    logic                        cap_ovf;

    // Both synchroniser chains freeze together with the rest of the state when clk_en is low.
    always_comb begin
        clk_sync_d = clk_sync_q;
        sel_sync_d = sel_sync_q;
        if (mon.clk_en) begin
            clk_sync_d[0] = mon.divided_clk;
            sel_sync_d[0] = mon.divided_clk_sel;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_d[i] = clk_sync_q[i-1];
                sel_sync_d[i] = sel_sync_q[i-1];
            end
        end
    end

    assign clk_sync_lvl = clk_sync_q[SYNC_STAGES-1];
    assign sel_sync_lvl = sel_sync_q[SYNC_STAGES-1];

    // Counters and FSM act on the registered events, so measurements update in the strobe cycle.
    assign edge_evt   = rise_evt_q | fall_evt_q;
    assign sel_change = mon.clk_en && (sel_sync_lvl != sel_hist_q);
    assign stall_trip = mon.clk_en && (mon.stall_limit != '0) &&
                        (stall_cnt_q == mon.stall_limit) && !edge_evt;
    assign cnt_at_max = (period_cnt_q == PERIOD_MAX);
    assign cap_period = cnt_at_max ? PERIOD_MAX : period_cnt_q + PERIOD_ONE;
    assign cap_ovf    = cnt_ovf_q | cnt_at_max;

    always_comb begin
        clk_hist_d     = clk_hist_q;
        sel_hist_d     = sel_hist_q;
        rise_evt_d     = rise_evt_q;
        fall_evt_d     = fall_evt_q;
        rise_strobe_d  = rise_strobe_q;
        fall_strobe_d  = fall_strobe_q;
        state_d        = state_q;
        period_cnt_d   = period_cnt_q;
        cnt_ovf_d      = cnt_ovf_q;
        period_out_d   = period_out_q;
        period_ovf_d   = period_ovf_q;
        period_valid_d = period_valid_q;
        stall_cnt_d    = stall_cnt_q;
        stalled_d      = stalled_q;

        if (mon.clk_en) begin
            clk_hist_d    = clk_sync_lvl;
            sel_hist_d    = sel_sync_lvl;
            rise_evt_d    = clk_sync_lvl & ~clk_hist_q;
            fall_evt_d    = ~clk_sync_lvl & clk_hist_q;
            rise_strobe_d = rise_evt_q;
            fall_strobe_d = fall_evt_q;

            if (edge_evt) begin
                stall_cnt_d = '0;
            end else if (stall_cnt_q != STALL_MAX) begin
                stall_cnt_d = stall_cnt_q + STALL_ONE;
            end

            // The period counter holds the cycles elapsed since the last rise, minus one.
            if (rise_evt_q) begin
                period_cnt_d = '0;
                cnt_ovf_d    = 1'b0;
            end else if (cnt_at_max) begin
                cnt_ovf_d    = 1'b1;
            end else begin
                period_cnt_d = period_cnt_q + PERIOD_ONE;
            end

            if (sel_change || stall_trip) begin
                state_d        = ST_WAIT_FIRST;
                period_valid_d = 1'b0;
                period_cnt_d   = '0;
                cnt_ovf_d      = 1'b0;
            end else if (rise_evt_q) begin
                case (state_q)
                    ST_WAIT_FIRST: begin
                        state_d = ST_WAIT_SECOND;
                    end
                    ST_WAIT_SECOND, ST_LOCKED: begin
                        state_d        = ST_LOCKED;
                        period_out_d   = cap_period;
                        period_ovf_d   = cap_ovf;
                        period_valid_d = 1'b1;
                    end
                    default: begin
                        state_d = ST_WAIT_FIRST;
                    end
                endcase
            end

            // Clearing causes take priority over a trip in the same cycle.
            if (mon.stall_limit == '0) begin
                stalled_d = 1'b0;
            end else if (edge_evt || sel_change) begin
                stalled_d = 1'b0;
            end else if (stall_trip) begin
                stalled_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge async_rst) begin
        if (!async_rst) begin
            clk_sync_q     <= '0;
            sel_sync_q     <= '0;
            clk_hist_q     <= 1'b0;
            sel_hist_q     <= 2'b00;
            rise_evt_q     <= 1'b0;
            fall_evt_q     <= 1'b0;
            rise_strobe_q  <= 1'b0;
            fall_strobe_q  <= 1'b0;
            state_q        <= ST_WAIT_FIRST;
            period_cnt_q   <= '0;
            cnt_ovf_q      <= 1'b0;
            period_out_q   <= '0;
            period_ovf_q   <= 1'b0;
            period_valid_q <= 1'b0;
            stall_cnt_q    <= '0;
            stalled_q      <= 1'b0;
        end else begin
            clk_sync_q     <= clk_sync_d;
            sel_sync_q     <= sel_sync_d;
            clk_hist_q     <= clk_hist_d;
            sel_hist_q     <= sel_hist_d;
            rise_evt_q     <= rise_evt_d;
            fall_evt_q     <= fall_evt_d;
            rise_strobe_q  <= rise_strobe_d;
            fall_strobe_q  <= fall_strobe_d;
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            cnt_ovf_q      <= cnt_ovf_d;
            period_out_q   <= period_out_d;
            period_ovf_q   <= period_ovf_d;
            period_valid_q <= period_valid_d;
            stall_cnt_q    <= stall_cnt_d;
            stalled_q      <= stalled_d;
        end
    end

    // Strobes are masked while disabled; a pending strobe reappears for one enabled cycle.
    assign mon.rise_strobe      = rise_strobe_q & mon.clk_en;
    assign mon.fall_strobe      = fall_strobe_q & mon.clk_en;
    assign mon.divided_clk_sync = clk_sync_lvl;
    assign mon.sel_sync         = sel_sync_lvl;
    assign mon.period_out       = period_out_q;
    assign mon.period_valid     = period_valid_q;
    assign mon.period_ovf       = period_ovf_q;
    assign mon.stalled          = stalled_q;

endmodule

// File: doc/io_clk_edge_monitor.md
Name: io_clk_edge_monitor

Overview:
- Sys_clk-domain consumer of the divided IO clock produced by the IO clock generation cell.
- Synchronises divided_clk and its source-select code into sys_clk.
- Emits single-cycle rise/fall strobes for IO peripherals running on sys_clk.
- Measures the divided clock period in sys_clk cycles and flags a stalled clock, so software can read back and verify the programmed divisor.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count for divided_clk and divided_clk_sel (legal 2..4).
- PERIOD_W, 16, width of period counter and period_out.
- STALL_W, 16, width of stall counter and stall_limit.

Ports:
- sys_clk  in  1  system clock; the only clock.
- async_rst  in  1  asynchronous reset, active-low; assertion is immediate, release is synchronous to sys_clk.
- clk_en  in  1  global clock enable; when low, all state holds and strobes are 0.
- divided_clk  in  1  divided IO clock; asynchronous to sys_clk.
- divided_clk_sel  in  2  source-select code accompanying divided_clk; asynchronous, quasi-static.
- stall_limit  in  STALL_W  enabled cycles without any edge before stalled asserts; 0 disables the watchdog.
- rise_strobe  out  1  one-cycle pulse per synchronised rising edge.
- fall_strobe  out  1  one-cycle pulse per synchronised falling edge.
- divided_clk_sync  out  1  synchronised level of divided_clk.
- sel_sync  out  2  synchronised divided_clk_sel.
- period_out  out  PERIOD_W  sys_clk cycles between the last two rising edges.
- period_valid  out  1  period_out holds a valid measurement.
- period_ovf  out  1  last measurement saturated.
- stalled  out  1  watchdog tripped.

Behaviour:
- Reset (async_rst=0): all flops 0, FSM=WAIT_FIRST. All outputs 0.
- Synchroniser and history:
  - SYNC_STAGES-flop chain on divided_clk, plus one history flop.
  - rise_evt = sync & ~hist; fall_evt = ~sync & hist.
  - rise_strobe and fall_strobe are registered copies of these events.
- Strobe latency: the first sys_clk edge that samples divided_clk=1 is edge 0. rise_strobe is high for exactly the one cycle following edge SYNC_STAGES+1. Fall latency is identical.
- Strobes only advance and assert while clk_en=1. A rise_strobe and fall_strobe never assert in the same cycle.
- sel_sync: SYNC_STAGES flops plus a history register. sel_change = (sel_sync != sel_hist), evaluated only when clk_en=1.
- Period counter:
  - Clears on rise_evt; otherwise increments each enabled cycle.
  - Saturates at 2^PERIOD_W-1 and sets an internal ovf bit.
  - For rises P enabled cycles apart, the captured value equals P.
- FSM states WAIT_FIRST, WAIT_SECOND, LOCKED:
  - WAIT_FIRST --rise_evt--> WAIT_SECOND, counter cleared.
  - WAIT_SECOND --rise_evt--> LOCKED: period_out<=count, period_ovf<=ovf, period_valid<=1.
  - LOCKED --rise_evt--> LOCKED, same update. This occurs every rise and overwrites the previous value.
  - Any state --sel_change or stall trip--> WAIT_FIRST: period_valid<=0, counter and ovf cleared. period_out retains its old value.
- Stall watchdog:
  - Counter clears on rise_evt or fall_evt; otherwise increments per enabled cycle, saturating at 2^STALL_W-1.
  - stalled<=1 when stall_limit!=0 and counter==stall_limit.
  - stalled<=0 on the next rise_evt or fall_evt, or on sel_change.
  - stall_limit=0 forces stalled=0.
- Simultaneous events:
  - sel_change with rise_evt: rise_strobe still asserts, and the FSM goes to WAIT_FIRST (the edge is not counted).
  - Stall trip and edge in the same cycle: the edge wins; no trip.
- Reset mid-operation: everything returns to reset values asynchronously; no strobe is produced on the reset-release cycle.

Test Plan:
- Generator source sys_clk, divisor 3 (divided period 8 sys_clk cycles), SYNC_STAGES=2 -> first rise_strobe 3 edges after sampling high; period_valid=1 after the 2nd rise with period_out=8; a fall_strobe lands 4 cycles after each rise_strobe.
- Divisor change 3->9 while LOCKED, sel_sync unchanged -> period_out goes 8 -> 20 on the first full new period; period_valid stays 1.
- divided_clk_sel 0->2 mid-run -> period_valid drops to 0 within SYNC_STAGES+2 cycles; FSM passes through WAIT_FIRST and WAIT_SECOND; valid again after two rises.
- divided_clk held high, stall_limit=50 -> stalled=1 after 50 edge-free enabled cycles, period_valid=0; a following fall clears stalled. With stall_limit=0 stalled never asserts.
- PERIOD_W=4, period 40 -> period_out=15, period_ovf=1; then period 8 -> period_out=8, period_ovf=0.
- clk_en low for 10 cycles spanning a divided_clk rise -> no strobes during that window, counters frozen; async_rst pulse mid-LOCKED -> all outputs 0 immediately and FSM in WAIT_FIRST after release.
